core_ctrl_fsm: RTL and testbench



---
 rtl/core_ctrl_fsm.sv | 178 +++++++++++++++++
 tb/tb_core_ctrl_fsm.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_ctrl_fsm.sv
// Multi-cycle control sequencer for the RV32I core: fetch, decode, execute,
// memory and writeback stepping, with retirement counting and trap detection.
module core_ctrl_fsm #(
  parameter int unsigned TIMEOUT_CYCLES = 0,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 instr_req_o,
  input  logic                 instr_gnt_i,
  input  logic                 instr_rvalid_i,
  output logic                 ir_we_o,
  input  logic                 instr_invalid_i,
  input  logic [1:0]           ctrl_transfer_instr_i,
  input  logic                 rd_used_i,
  input  logic                 data_req_i,
  input  logic                 data_we_i,
  input  logic                 branch_taken_i,
  output logic                 data_req_o,
  output logic                 data_we_o,
  input  logic                 data_gnt_i,
  input  logic                 data_rvalid_i,
  output logic                 rf_we_o,
  output logic                 pc_we_o,
  output logic [1:0]           pc_mux_sel_o,
  output logic                 illegal_instr_o,
  output logic                 bus_err_o,
  output logic [CNT_WIDTH-1:0] instret_o,
  output logic [2:0]           state_o
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    FETCH      = 3'd1,
    WAIT_INSTR = 3'd2,
    DECODE     = 3'd3,
    EXECUTE    = 3'd4,
    MEM        = 3'd5,
    MEM_WAIT   = 3'd6,
    TRAP       = 3'd7
  } state_t;

  localparam bit          TMO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES) - 32'd1;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] tmo_cnt;
  logic        waiting;
  logic        handshake;
  logic        set_ill;
  logic        set_berr;

  always_comb begin
    state_nxt    = state;
    instr_req_o  = 1'b0;
    ir_we_o      = 1'b0;
    data_req_o   = 1'b0;
    data_we_o    = 1'b0;
    rf_we_o      = 1'b0;
    pc_we_o      = 1'b0;
    pc_mux_sel_o = 2'b00;
    waiting      = 1'b0;
    handshake    = 1'b0;
    set_ill      = 1'b0;
    set_berr     = 1'b0;
    case (state)
      IDLE: state_nxt = FETCH;
      FETCH: begin
        instr_req_o = 1'b1;
        waiting     = 1'b1;
        handshake   = instr_gnt_i;
        if (instr_gnt_i) begin
          if (instr_rvalid_i) begin
            ir_we_o   = 1'b1;
            state_nxt = DECODE;
          end else begin
            state_nxt = WAIT_INSTR;
          end
        end
      end
      WAIT_INSTR: begin
        waiting   = 1'b1;
        handshake = instr_rvalid_i;
        if (instr_rvalid_i) begin
          ir_we_o   = 1'b1;
          state_nxt = DECODE;
        end
      end
      DECODE: begin
        if (instr_invalid_i) begin
          set_ill   = 1'b1;
          state_nxt = TRAP;
        end else begin
          state_nxt = EXECUTE;
        end
      end
      EXECUTE: begin
        if (ctrl_transfer_instr_i == 2'b01) begin
          pc_mux_sel_o = 2'b01;
        end else if (ctrl_transfer_instr_i == 2'b10 && branch_taken_i) begin
          pc_mux_sel_o = 2'b10;
        end
        if (data_req_i) begin
          state_nxt = MEM;
        end else begin
          pc_we_o   = 1'b1;
          rf_we_o   = rd_used_i;
          state_nxt = FETCH;
        end
      end
      MEM: begin
        data_req_o = 1'b1;
        data_we_o  = data_we_i;
        waiting    = 1'b1;
        handshake  = data_gnt_i;
        if (data_gnt_i) begin
          if (data_we_i) begin
            pc_we_o   = 1'b1;
            state_nxt = FETCH;
          end else if (data_rvalid_i) begin
            // Load data already back with the grant: complete writeback now.
            rf_we_o   = 1'b1;
            pc_we_o   = 1'b1;
            state_nxt = FETCH;
          end else begin
            state_nxt = MEM_WAIT;
          end
        end
      end
      MEM_WAIT: begin
        waiting   = 1'b1;
        handshake = data_rvalid_i;
        if (data_rvalid_i) begin
          rf_we_o   = 1'b1;
          pc_we_o   = 1'b1;
          state_nxt = FETCH;
        end
      end
      TRAP: state_nxt = TRAP;
      default: state_nxt = IDLE;
    endcase
    // A handshake in the expiry cycle takes priority over the timeout.
    if (TMO_EN && waiting && !handshake && tmo_cnt == TMO_LAST) begin
      set_berr  = 1'b1;
      state_nxt = TRAP;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      tmo_cnt         <= 32'd0;
      instret_o       <= '0;
      illegal_instr_o <= 1'b0;
      bus_err_o       <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) begin
        tmo_cnt <= 32'd0;
      end else if (TMO_EN && waiting && !handshake) begin
        tmo_cnt <= tmo_cnt + 32'd1;
      end
      if (pc_we_o) begin
        instret_o <= instret_o + CNT_WIDTH'(1);
      end
      if (set_ill) begin
        illegal_instr_o <= 1'b1;
      end
      if (set_berr) begin
        bus_err_o <= 1'b1;
      end
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_core_ctrl_fsm.sv
// Directed bench for core_ctrl_fsm: an instruction-level trace model expands
// each instruction's handshake delays into the cycle-by-cycle expected outputs.
module tb_core_ctrl_fsm;

  localparam int TMO = 4;
  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_WAITI = 3'd2, S_DEC = 3'd3,
                         S_EXE = 3'd4, S_MEM = 3'd5, S_MEMW = 3'd6, S_TRAP = 3'd7;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_req_o, instr_gnt_i, instr_rvalid_i, ir_we_o, instr_invalid_i;
  logic [1:0]  ctrl_transfer_instr_i;
  logic        rd_used_i, data_req_i, data_we_i, branch_taken_i;
  logic        data_req_o, data_we_o, data_gnt_i, data_rvalid_i, rf_we_o, pc_we_o;
  logic [1:0]  pc_mux_sel_o;
  logic        illegal_instr_o, bus_err_o;
  logic [31:0] instret_o;
  logic [2:0]  state_o;

  core_ctrl_fsm #(.TIMEOUT_CYCLES(TMO), .CNT_WIDTH(32)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .instr_req_o           (instr_req_o),
    .instr_gnt_i           (instr_gnt_i),
    .instr_rvalid_i        (instr_rvalid_i),
    .ir_we_o               (ir_we_o),
    .instr_invalid_i       (instr_invalid_i),
    .ctrl_transfer_instr_i (ctrl_transfer_instr_i),
    .rd_used_i             (rd_used_i),
    .data_req_i            (data_req_i),
    .data_we_i             (data_we_i),
    .branch_taken_i        (branch_taken_i),
    .data_req_o            (data_req_o),
    .data_we_o             (data_we_o),
    .data_gnt_i            (data_gnt_i),
    .data_rvalid_i         (data_rvalid_i),
    .rf_we_o               (rf_we_o),
    .pc_we_o               (pc_we_o),
    .pc_mux_sel_o          (pc_mux_sel_o),
    .illegal_instr_o       (illegal_instr_o),
    .bus_err_o             (bus_err_o),
    .instret_o             (instret_o),
    .state_o               (state_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        inv;
    logic [1:0]  ct;
    logic        rdu, dm, dw, bt, ig, irv, dg, drv;
    logic [2:0]  st;
    logic        ireq, irwe, dreq_o, dwe_o, rfwe, pcwe;
    logic [1:0]  sel;
    logic [31:0] ret;
    logic        ill, berr;
  } rec_t;

  rec_t        exp_q[$];
  rec_t        cur;
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  logic [31:0] m_ret;
  logic        m_ill, m_berr;
  logic        d_inv;
  logic [1:0]  d_ct;
  logic        d_rdu, d_dm, d_dw, d_bt;
  int          n_rf, n_pc, n_ir, n_ld, n_fetch, n_sel;
  logic [1:0]  sel_log[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic rec_t blank(input logic [2:0] st);
    rec_t r;
    r     = '0;
    r.inv = d_inv; r.ct = d_ct; r.rdu = d_rdu; r.dm = d_dm; r.dw = d_dw; r.bt = d_bt;
    r.st  = st;
    return r;
  endfunction

  function automatic void push(input rec_t r_in);
    rec_t r;
    r      = r_in;
    r.ret  = m_ret;
    r.ill  = m_ill;
    r.berr = m_berr;
    exp_q.push_back(r);
  endfunction

  function automatic void traps(input int n);
    for (int i = 0; i < n; i++) push(blank(S_TRAP));
  endfunction

  // n cycles without the awaited handshake; returns 1 if that exhausts the timeout.
  function automatic bit stall(input logic [2:0] st, input int n);
    rec_t r;
    int   k;
    k = (TMO != 0 && n > TMO) ? TMO : n;
    for (int i = 0; i < k; i++) begin
      r        = blank(st);
      r.ireq   = (st == S_FETCH);
      r.dreq_o = (st == S_MEM);
      r.dwe_o  = (st == S_MEM) && d_dw;
      push(r);
    end
    if (TMO != 0 && n >= TMO) begin
      m_berr = 1'b1;
      traps(3);
      return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic void start_prog();
    m_ret = 32'd0; m_ill = 1'b0; m_berr = 1'b0;
    d_inv = 1'b0; d_ct = 2'b00; d_rdu = 1'b0; d_dm = 1'b0; d_dw = 1'b0; d_bt = 1'b0;
    exp_q.delete();
    push(blank(S_IDLE));
  endfunction

  // fg: fetch cycles before gnt; fr: cycles from gnt to rvalid (0 = same cycle);
  // mg/mr: the same for the data bus.
  task automatic add_instr(input logic inv, input logic [1:0] ct, input logic rdu,
                           input logic dm, input logic dw, input logic bt,
                           input int fg, input int fr, input int mg, input int mr);
    rec_t r;
    d_inv = inv; d_ct = ct; d_rdu = rdu; d_dm = dm; d_dw = dw; d_bt = bt;
    if (stall(S_FETCH, fg)) return;
    r = blank(S_FETCH); r.ireq = 1'b1; r.ig = 1'b1;
    if (fr == 0) begin
      r.irv = 1'b1; r.irwe = 1'b1; push(r);
    end else begin
      push(r);
      if (stall(S_WAITI, fr - 1)) return;
      r = blank(S_WAITI); r.irv = 1'b1; r.irwe = 1'b1; push(r);
    end
    push(blank(S_DEC));
    if (inv) begin
      m_ill = 1'b1;
      traps(3);
      return;
    end
    r     = blank(S_EXE);
    r.sel = (ct == 2'b01) ? 2'b01 : ((ct == 2'b10 && bt) ? 2'b10 : 2'b00);
    if (!dm) begin
      r.pcwe = 1'b1; r.rfwe = rdu; push(r); m_ret++;
      return;
    end
    push(r);
    if (stall(S_MEM, mg)) return;
    r = blank(S_MEM); r.dreq_o = 1'b1; r.dwe_o = dw; r.dg = 1'b1; r.drv = (mr == 0);
    if (dw || mr == 0) begin
      r.pcwe = 1'b1; r.rfwe = !dw; push(r); m_ret++;
      return;
    end
    push(r);
    if (stall(S_MEMW, mr - 1)) return;
    r = blank(S_MEMW); r.drv = 1'b1; r.rfwe = 1'b1; r.pcwe = 1'b1; push(r); m_ret++;
  endtask

  task automatic idle_inputs();
    instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0; instr_invalid_i = 1'b0;
    ctrl_transfer_instr_i = 2'b00; rd_used_i = 1'b0; data_req_i = 1'b0;
    data_we_i = 1'b0; branch_taken_i = 1'b0; data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
  endtask

  task automatic run_trace(input int n);
    for (int i = 0; i < n && i < exp_q.size(); i++) begin
      cur = exp_q[i];
      instr_gnt_i = cur.ig; instr_rvalid_i = cur.irv; instr_invalid_i = cur.inv;
      ctrl_transfer_instr_i = cur.ct; rd_used_i = cur.rdu; data_req_i = cur.dm;
      data_we_i = cur.dw; branch_taken_i = cur.bt; data_gnt_i = cur.dg;
      data_rvalid_i = cur.drv;
      @(negedge clk);
      cyc++;
      chk("state",     32'(state_o),         32'(cur.st));
      chk("instr_req", 32'(instr_req_o),     32'(cur.ireq));
      chk("ir_we",     32'(ir_we_o),         32'(cur.irwe));
      chk("data_req",  32'(data_req_o),      32'(cur.dreq_o));
      chk("data_we",   32'(data_we_o),       32'(cur.dwe_o));
      chk("rf_we",     32'(rf_we_o),         32'(cur.rfwe));
      chk("pc_we",     32'(pc_we_o),         32'(cur.pcwe));
      chk("pc_sel",    32'(pc_mux_sel_o),    32'(cur.sel));
      chk("instret",   instret_o,            cur.ret);
      chk("illegal",   32'(illegal_instr_o), 32'(cur.ill));
      chk("bus_err",   32'(bus_err_o),       32'(cur.berr));
      if (rf_we_o) n_rf++;
      if (ir_we_o) n_ir++;
      if (data_req_o && !data_we_o) n_ld++;
      if (state_o == S_FETCH) n_fetch++;
      if (pc_we_o) begin
        n_pc++;
        if (n_sel < 8) sel_log[n_sel] = pc_mux_sel_o;
        n_sel++;
      end
      @(posedge clk);
      #1;
    end
    idle_inputs();
    exp_q.delete();
  endtask

  task automatic lit_reset(input string tag);
    chk({tag, "_state"},   32'(state_o),         32'd0);
    chk({tag, "_instret"}, instret_o,            32'd0);
    chk({tag, "_illegal"}, 32'(illegal_instr_o), 32'd0);
    chk({tag, "_bus_err"}, 32'(bus_err_o),       32'd0);
    chk({tag, "_strobes"},
        32'({instr_req_o, ir_we_o, data_req_o, data_we_o, rf_we_o, pc_we_o}), 32'd0);
  endtask

  task automatic clear_counts();
    n_rf = 0; n_pc = 0; n_ir = 0; n_ld = 0; n_fetch = 0; n_sel = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    clear_counts();
    #1;
    lit_reset("rst0");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // ADDI, BEQ taken, BEQ not taken, JAL, LW (slow), SW (gnt+rvalid together), illegal
    start_prog();
    add_instr(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1, 0, 0);
    add_instr(1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0);
    add_instr(1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 0, 2, 0, 0);
    add_instr(1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 2, 1, 0, 0);
    add_instr(1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 3, 2);
    add_instr(1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 0, 0);
    add_instr(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
    clear_counts();
    run_trace(exp_q.size());
    chk("A_instret",   instret_o,            32'd6);
    chk("A_state",     32'(state_o),         32'd7);
    chk("A_illegal",   32'(illegal_instr_o), 32'd1);
    chk("A_instr_req", 32'(instr_req_o),     32'd0);
    chk("A_rf_pulses", 32'(n_rf),            32'd3);
    chk("A_pc_pulses", 32'(n_pc),            32'd6);
    chk("A_ir_pulses", 32'(n_ir),            32'd7);
    chk("A_ld_req",    32'(n_ld),            32'd4);
    chk("A_sel_addi",  32'(sel_log[0]),      32'd0);
    chk("A_sel_beqt",  32'(sel_log[1]),      32'd2);
    chk("A_sel_beqn",  32'(sel_log[2]),      32'd0);
    chk("A_sel_jal",   32'(sel_log[3]),      32'd1);

    rst_n = 1'b0;
    #1;
    lit_reset("rstA");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Fetch never granted: bus timeout after TMO cycles in FETCH
    start_prog();
    add_instr(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1000, 0, 0, 0);
    clear_counts();
    run_trace(exp_q.size());
    chk("B_state",   32'(state_o),         32'd7);
    chk("B_bus_err", 32'(bus_err_o),       32'd1);
    chk("B_illegal", 32'(illegal_instr_o), 32'd0);
    chk("B_fetch",   32'(n_fetch),         32'd4);

    rst_n = 1'b0;
    #1;
    lit_reset("rstB");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Reset asserted while a load is waiting for its grant
    start_prog();
    add_instr(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
    add_instr(1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 3, 0);
    run_trace(9);
    chk("C_pre_state",   32'(state_o), 32'd5);
    chk("C_pre_instret", instret_o,    32'd1);
    rst_n = 1'b0;
    #1;
    lit_reset("abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
